// File: rtl/mb_ascii_rx_framer.sv
// Modbus ASCII receive framer: hex-pair decode into a byte buffer, LRC/length/address qualification, frame hold until ack.
// Optional inter-character timeout is built only when MB_ASCII_RX_TIMEOUT_EN is defined.
module mb_ascii_rx_framer #(
  parameter int DEPTH            = 256,
  parameter int ACCEPT_BROADCAST = 1,
  parameter int TIMEOUT_CYCLES   = 50000000,
  localparam int AW              = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  input  logic [7:0]    slave_addr,
  input  logic [7:0]    lf_char,
  output logic          frame_valid,
  output logic [AW-1:0] frame_len,
  output logic [7:0]    frame_addr,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          frame_ack,
  output logic          busy,
  output logic          err_char,
  output logic          err_overflow,
  output logic          err_lrc,
  output logic          err_short,
  output logic          err_timeout,
  output logic          addr_miss,
  output logic          rx_drop
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RCV, S_WAIT_EOF, S_DONE} state_t;

  state_t          state_q;
  logic [AW-1:0]   pos_q;
  logic [7:0]      lrc_q;
  logic            nib_lo_q;
  logic [3:0]      hi_q;
  logic [7:0]      frame_addr_q;
  logic [AW-1:0]   frame_len_q;
  logic [7:0]      rd_data_q;
  logic            err_char_q, err_overflow_q, err_lrc_q, err_short_q;
  logic            err_timeout_q, addr_miss_q, rx_drop_q;
  logic [7:0]      mem [DEPTH];

  logic            is_hex;
  logic [3:0]      nib;
  logic [7:0]      byte_d;
  logic [7:0]      lrc_d;
  logic            pos_full;
  logic            start;
  logic            addr_ok;
  logic            wr_en;
  logic            timeout_hit;

  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = rx_byte[3:0] + 4'd9;
    end
    byte_d   = {hi_q, nib};
    lrc_d    = lrc_q + byte_d;
    pos_full = (pos_q == AW'(DEPTH));
    // A coincident ack frees the buffer, so ':' is honoured in DONE only then.
    start    = rx_valid && (rx_byte == 8'h3A) && (state_q != S_DONE || frame_ack);
    addr_ok  = (frame_addr_q == slave_addr) ||
               ((ACCEPT_BROADCAST != 0) && (frame_addr_q == 8'h00));
    wr_en    = rx_valid && (state_q == S_RCV) && is_hex && nib_lo_q && !pos_full;
  end

`ifdef MB_ASCII_RX_TIMEOUT_EN
  logic [31:0] tcnt_q;

  always_ff @(posedge clk) begin
    if (rst || rx_valid || !(state_q == S_RCV || state_q == S_WAIT_EOF)) tcnt_q <= '0;
    else                                                                  tcnt_q <= tcnt_q + 32'd1;
  end

  always_comb begin
    timeout_hit = (state_q == S_RCV || state_q == S_WAIT_EOF) && !rx_valid &&
                  (tcnt_q == 32'(TIMEOUT_CYCLES - 1));
  end
`else
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[pos_q[IW-1:0]] <= byte_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pos_q          <= '0;
      lrc_q          <= '0;
      nib_lo_q       <= 1'b0;
      hi_q           <= '0;
      frame_addr_q   <= '0;
      frame_len_q    <= '0;
      rd_data_q      <= '0;
      err_char_q     <= 1'b0;
      err_overflow_q <= 1'b0;
      err_lrc_q      <= 1'b0;
      err_short_q    <= 1'b0;
      err_timeout_q  <= 1'b0;
      addr_miss_q    <= 1'b0;
      rx_drop_q      <= 1'b0;
    end else begin
      err_char_q     <= 1'b0;
      err_overflow_q <= 1'b0;
      err_lrc_q      <= 1'b0;
      err_short_q    <= 1'b0;
      err_timeout_q  <= 1'b0;
      addr_miss_q    <= 1'b0;
      rx_drop_q      <= 1'b0;
      if (rd_addr < AW'(DEPTH)) rd_data_q <= mem[rd_addr[IW-1:0]];

      if (start) begin
        state_q  <= S_RCV;
        pos_q    <= '0;
        lrc_q    <= '0;
        nib_lo_q <= 1'b0;
      end else if (state_q == S_DONE) begin
        if (frame_ack)     state_q   <= S_IDLE;
        else if (rx_valid) rx_drop_q <= 1'b1;
      end else if (rx_valid) begin
        case (state_q)
          S_RCV: begin
            if (is_hex) begin
              if (!nib_lo_q) begin
                hi_q     <= nib;
                nib_lo_q <= 1'b1;
              end else if (pos_full) begin
                err_overflow_q <= 1'b1;
                state_q        <= S_IDLE;
              end else begin
                pos_q    <= pos_q + AW'(1);
                lrc_q    <= lrc_d;
                nib_lo_q <= 1'b0;
                if (pos_q == '0) frame_addr_q <= byte_d;
              end
            end else if (rx_byte == 8'h0D && !nib_lo_q) begin
              state_q <= S_WAIT_EOF;
            end else begin
              err_char_q <= 1'b1;
              state_q    <= S_IDLE;
            end
          end
          S_WAIT_EOF: begin
            if (rx_byte == lf_char) begin
              if (pos_q < AW'(3)) begin
                err_short_q <= 1'b1;
                state_q     <= S_IDLE;
              end else if (lrc_q != 8'h00) begin
                err_lrc_q <= 1'b1;
                state_q   <= S_IDLE;
              end else if (!addr_ok) begin
                addr_miss_q <= 1'b1;
                state_q     <= S_IDLE;
              end else begin
                frame_len_q <= pos_q - AW'(1);
                state_q     <= S_DONE;
              end
            end else begin
              err_char_q <= 1'b1;
              state_q    <= S_IDLE;
            end
          end
          default: ;
        endcase
      end else if (timeout_hit) begin
        err_timeout_q <= 1'b1;
        state_q       <= S_IDLE;
      end
    end
  end

  assign frame_valid  = (state_q == S_DONE);
  assign busy         = (state_q == S_RCV) || (state_q == S_WAIT_EOF);
  assign frame_len    = frame_len_q;
  assign frame_addr   = frame_addr_q;
  assign rd_data      = rd_data_q;
  assign err_char     = err_char_q;
  assign err_overflow = err_overflow_q;
  assign err_lrc      = err_lrc_q;
  assign err_short    = err_short_q;
  assign err_timeout  = err_timeout_q;
  assign addr_miss    = addr_miss_q;
  assign rx_drop      = rx_drop_q;

endmodule

// File: tb/tb_mb_ascii_rx_framer.sv
// Scoreboard bench for mb_ascii_rx_framer: two instances (DEPTH 256 with broadcast, DEPTH 8 without) share the byte stream.
module tb_mb_ascii_rx_framer;

  localparam logic [7:0] EV_FRAME = 8'h01, EV_CHAR = 8'h02, EV_OVF  = 8'h04, EV_LRC  = 8'h08;
  localparam logic [7:0] EV_SHORT = 8'h10, EV_TMO  = 8'h20, EV_MISS = 8'h40, EV_DROP = 8'h80;

  typedef struct {
    logic [7:0] vec;
    int         len;
    logic [7:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst, rx_valid, frame_ack, rd_req, rd_req_d;
  logic [7:0] rx_byte;
  logic [8:0] rd_addr0;
  logic [3:0] rd_addr1;

  logic       fv0, busy0, ec0, eo0, el0, es0, et0, am0, rd0;
  logic [8:0] len0;
  logic [7:0] addr0, rdd0;
  logic       fv1, busy1, ec1, eo1, el1, es1, et1, am1, rd1;
  logic [3:0] len1;
  logic [7:0] addr1, rdd1;

  logic fvp0 = 1'b0, fvp1 = 1'b0;
  int checks = 0, errors = 0;
  exp_t q0[$], q1[$];
  logic [7:0] rq[$];

  always #5 clk = ~clk;

  mb_ascii_rx_framer #(.DEPTH(256), .ACCEPT_BROADCAST(1), .TIMEOUT_CYCLES(100)) u0 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .slave_addr(8'h0A),
    .lf_char(8'h0A), .frame_valid(fv0), .frame_len(len0), .frame_addr(addr0),
    .rd_addr(rd_addr0), .rd_data(rdd0), .frame_ack(frame_ack), .busy(busy0),
    .err_char(ec0), .err_overflow(eo0), .err_lrc(el0), .err_short(es0),
    .err_timeout(et0), .addr_miss(am0), .rx_drop(rd0));

  mb_ascii_rx_framer #(.DEPTH(8), .ACCEPT_BROADCAST(0), .TIMEOUT_CYCLES(100)) u1 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .slave_addr(8'h0A),
    .lf_char(8'h0A), .frame_valid(fv1), .frame_len(len1), .frame_addr(addr1),
    .rd_addr(rd_addr1), .rd_data(rdd1), .frame_ack(frame_ack), .busy(busy1),
    .err_char(ec1), .err_overflow(eo1), .err_lrc(el1), .err_short(es1),
    .err_timeout(et1), .addr_miss(am1), .rx_drop(rd1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic [7:0] obs, input int len, input logic [7:0] addr);
    exp_t e;
    if (obs == 8'h00) return;
    checks++;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL u%0d unexpected event: got vec 0x%02h expected none", id, obs);
      return;
    end
    e = (id == 0) ? q0.pop_front() : q1.pop_front();
    if (obs !== e.vec || (obs[0] && (len != e.len || addr !== e.addr))) begin
      errors++;
      $display("FAIL u%0d event: got vec 0x%02h len %0d addr 0x%02h expected vec 0x%02h len %0d addr 0x%02h",
               id, obs, len, addr, e.vec, e.len, e.addr);
    end
  endtask

  always @(posedge clk) rd_req_d <= rd_req;

  always @(negedge clk) begin
    logic [7:0] exp_rd;
    mon(0, {rd0, am0, et0, es0, el0, eo0, ec0, fv0 & ~fvp0}, int'(len0), addr0);
    mon(1, {rd1, am1, et1, es1, el1, eo1, ec1, fv1 & ~fvp1}, int'(len1), addr1);
    fvp0 = fv0;
    fvp1 = fv1;
    if (rd_req_d) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rd_data: got 0x%02h expected no read pending", rdd0);
      end else begin
        exp_rd = rq.pop_front();
        if (rdd0 !== exp_rd) begin
          errors++;
          $display("FAIL rd_data: got 0x%02h expected 0x%02h", rdd0, exp_rd);
        end
      end
    end
  end

  task automatic expect_evt(input int id, input logic [7:0] vec, input int len = 0,
                            input logic [7:0] addr = 8'h00);
    exp_t e;
    e.vec = vec; e.len = len; e.addr = addr;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic send_ch(input logic [7:0] c);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = c;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_ch(s[i]);
  endtask

  task automatic send_frame(input string s);
    send_str(s);
    send_ch(8'h0D);
    send_ch(8'h0A);
  endtask

  task automatic rd(input int a, input logic [7:0] e);
    @(negedge clk);
    rd_addr0 = 9'(a);
    rd_req   = 1'b1;
    rq.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    chk("fv0 after ack", {63'd0, fv0}, 64'd0);
    chk("fv1 after ack", {63'd0, fv1}, 64'd0);
  endtask

  task automatic chk_zero();
    chk("u0 outputs in reset", {30'd0, fv0, len0, addr0, rdd0, busy0, ec0, eo0, el0, es0, et0, am0, rd0}, 64'd0);
    chk("u1 outputs in reset", {35'd0, fv1, len1, addr1, rdd1, busy1, ec1, eo1, el1, es1, et1, am1, rd1}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] f1 [6];
    logic [7:0] fo [8];
    f1 = '{8'h0A, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
    fo = '{8'h0A, 8'h10, 8'h00, 8'h01, 8'h00, 8'h02, 8'h04, 8'h00};
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; frame_ack = 1'b0;
    rd_req = 1'b0; rd_addr0 = '0; rd_addr1 = '0;
    repeat (3) @(negedge clk);
    chk_zero();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    expect_evt(0, EV_FRAME, 6, 8'h0A);
    expect_evt(1, EV_FRAME, 6, 8'h0A);
    send_frame(":0A0300000001F2");
    chk("fv0 after frame", {63'd0, fv0}, 64'd1);
    for (int i = 0; i < 6; i++) rd(i, f1[i]);
    ack();

    expect_evt(0, EV_LRC);  expect_evt(1, EV_LRC);
    send_frame(":0A0300000001F3");
    expect_evt(0, EV_MISS); expect_evt(1, EV_MISS);
    send_frame(":0B0300000001F1");
    expect_evt(0, EV_FRAME, 6, 8'h00); expect_evt(1, EV_MISS);
    send_frame(":000300000001FC");
    ack();

    expect_evt(0, EV_CHAR);  expect_evt(1, EV_CHAR);
    send_frame(":0A3");
    expect_evt(0, EV_SHORT); expect_evt(1, EV_SHORT);
    send_frame(":0AF6");
    expect_evt(0, EV_FRAME, 6, 8'h0A); expect_evt(1, EV_FRAME, 6, 8'h0A);
    send_frame(":0A03:0A0300000001F2");
    ack();
    expect_evt(0, EV_CHAR);  expect_evt(1, EV_CHAR);
    send_str(":0G");

    expect_evt(0, EV_FRAME, 8, 8'h0A); expect_evt(1, EV_OVF);
    send_frame(":0A10000100020400DF");
    chk("u1 busy after overflow", {63'd0, busy1}, 64'd0);
    for (int i = 0; i < 5; i++) expect_evt(0, EV_DROP);
    send_str(":0A03");
    for (int i = 0; i < 8; i++) rd(i, fo[i]);

    expect_evt(0, EV_FRAME, 6, 8'h0A); expect_evt(1, EV_FRAME, 6, 8'h0A);
    @(negedge clk);
    rx_valid = 1'b1; rx_byte = 8'h3A; frame_ack = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; frame_ack = 1'b0;
    chk("fv0 after ack with colon", {63'd0, fv0}, 64'd0);
    send_frame("0A0300000001F2");
    for (int i = 0; i < 6; i++) rd(i, f1[i]);
    ack();

`ifdef MB_ASCII_RX_TIMEOUT_EN
    expect_evt(0, EV_TMO); expect_evt(1, EV_TMO);
    send_str(":0A03");
    repeat (150) @(negedge clk);
    chk("u0 busy after timeout", {63'd0, busy0}, 64'd0);
    send_str(":0A03");
`else
    send_str(":0A03");
    repeat (150) @(negedge clk);
    chk("u0 busy without timeout", {63'd0, busy0}, 64'd1);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero();
    rst = 1'b0;
    repeat (20) @(negedge clk);

    chk("u0 events outstanding", 64'(q0.size()), 64'd0);
    chk("u1 events outstanding", 64'(q1.size()), 64'd0);
    chk("reads outstanding", 64'(rq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mb_ascii_rx_framer.md
Name: mb_ascii_rx_framer

Overview:
- Parametrised Modbus ASCII receive framer. It sits between the portserial UART byte stream and the mb event logic.
- Runs the RX state machine, decodes hex nibble pairs into a byte buffer, and accumulates the LRC.
- Qualifies each frame on length, LRC and address, then holds the accepted frame for the event/execute logic.
- Generalises the fixed RX logic with parametrised buffer depth, a runtime LF character, explicit error reporting, and an optional inter-character timeout.

Parameters:
- DEPTH, 256, decoded-byte buffer capacity (address + PDU + LRC).
- ACCEPT_BROADCAST, 1, accept frames addressed to 0x00.
- TIMEOUT_CYCLES, 50000000, inter-character timeout in clk cycles (used only with the macro).
- Derived (not overridable): AW = $clog2(DEPTH+1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset synchronous active-high
- rx_valid  in  1  one-cycle strobe, received UART byte
- rx_byte  in  8  received character
- slave_addr  in  8  own Modbus address (1..247)
- lf_char  in  8  end-of-frame character (normally 0x0A)
- frame_valid  out  1  accepted frame held in buffer
- frame_len  out  AW  decoded bytes excluding LRC (address included)
- frame_addr  out  8  received address byte
- rd_addr  in  AW  buffer read index (0 = address)
- rd_data  out  8  buffer[rd_addr], registered, 1-cycle latency
- frame_ack  in  1  consumer done; releases buffer
- busy  out  1  state is RCV or WAIT_EOF
- err_char, err_overflow, err_lrc, err_short, err_timeout, addr_miss, rx_drop  out  1 each  one-cycle pulses

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - State = IDLE.
  - All outputs 0: frame_len=0, frame_addr=0, rd_data=0, all pulses low.
  - Internal counters cleared: pos=0, lrc=0, nibble=HIGH.
  - rst mid-frame discards the frame with no error pulse.
- States: IDLE, RCV, WAIT_EOF, DONE.
- ':' received in IDLE/RCV/WAIT_EOF:
  - Go to RCV; pos=0, lrc=0, nibble=HIGH.
  - A restart mid-frame is silent (no error pulse).
- RCV, hex character ('0'-'9', 'A'-'F', 'a'-'f'):
  - HIGH nibble: latch it, set nibble=LOW.
  - LOW nibble: byte = {hi, lo}.
    - If pos==DEPTH: err_overflow, go to IDLE.
    - Otherwise: buffer[pos]=byte, pos+=1, lrc=(lrc+byte) mod 256, nibble=HIGH.
  - The byte written at pos 0 is also latched into frame_addr.
- RCV, CR (0x0D):
  - nibble==HIGH → WAIT_EOF.
  - nibble==LOW (odd nibble count) → err_char, IDLE.
- RCV, any other character: err_char, IDLE.
- WAIT_EOF, byte == lf_char: evaluate in this priority order.
  - pos<3 → err_short, IDLE.
  - lrc!=0 → err_lrc, IDLE. The LRC byte is included in the sum.
  - Address mismatch → addr_miss, IDLE. A match is frame_addr==slave_addr, or frame_addr==0 with ACCEPT_BROADCAST=1.
  - Otherwise → DONE, with frame_len=pos-1.
  - frame_valid rises on the cycle after the lf_char strobe. All error pulses occur on that same cycle.
- WAIT_EOF, other non-':' character: err_char, IDLE.
- IDLE: non-':' characters are ignored with no pulse.
- DONE:
  - frame_valid=1; buffer contents, frame_len and frame_addr are stable.
  - Every rx_valid produces rx_drop and the byte is discarded.
  - frame_ack → IDLE; frame_valid deasserts on the next cycle.
  - frame_ack together with rx_valid: the byte is processed as in IDLE (':' starts a new frame, no rx_drop).
  - frame_ack outside DONE is ignored.
- rd_data is valid in any state, one cycle after rd_addr. Reads beyond frame_len return stale data.
- Simultaneous rx_valid and a timeout expiry: rx_valid wins and the counter reloads.

Optional Feature:
- Macro: MB_ASCII_RX_TIMEOUT_EN.
- Defined:
  - A counter runs in RCV/WAIT_EOF, cleared on each rx_valid.
  - When the counter reaches TIMEOUT_CYCLES-1: err_timeout pulse, go to IDLE.
- Undefined:
  - No counter logic is built; err_timeout is tied to 0.
  - A frame may wait indefinitely for the next character.

Test Plan:
- slave_addr=0x0A, send ":0A0300000001F2\r\n" → frame_valid, frame_len=6, frame_addr=0x0A, rd_data 0..5 = 0A 03 00 00 00 01; frame_ack → frame_valid=0 next cycle.
- Same frame with LRC "F3" → err_lrc pulse, no frame_valid. Frame ":0B0300000001F1\r\n" → addr_miss. Frame ":000300000001FC\r\n" → accepted; with ACCEPT_BROADCAST=0 → addr_miss.
- Error and restart cases:
  - ":0A3\r\n" (odd nibble count) → err_char.
  - ":0AF6\r\n" → err_short.
  - ":0A03:0A0300000001F2\r\n" → restart is silent; frame accepted.
  - ":0G..." → err_char.
- DEPTH=8, send 9 decoded bytes → err_overflow on the 9th byte, state IDLE.
- Buffer hold and release:
  - While DONE, send ":0A..." → rx_drop on each byte; buffer unchanged.
  - frame_ack coincident with ':' → new frame begins and is received correctly.
- With MB_ASCII_RX_TIMEOUT_EN, TIMEOUT_CYCLES=100: send ":0A03" then idle → err_timeout 100 cycles after the last byte. Rebuild without the macro → no pulse. Assert rst mid-frame → all outputs 0, no pulses.
